// File: rtl/spi_ram_pkg.sv
// Shared command encoding for the SPI-fed burst RAM.
// The top and the bench both decode command bits [DATA_W+1:DATA_W] of din with these codes.
package spi_ram_pkg;

    localparam int CMD_W = 2;

    typedef enum logic [CMD_W-1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

endpackage

// File: rtl/spi_ram_mem.sv
// Single-port-write / single-port-read word storage, synchronous on both sides, no reset.
// Address range checking is the caller's job.
module spi_ram_mem #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/spi_ram_burst.sv
// Command-driven RAM with auto-incrementing write/read pointers and a one-word
// tx holding stage with valid/ready back-pressure.
module spi_ram_burst
    import spi_ram_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 2**ADDR_W,
    parameter int AUTO_INC  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W+1:0] din,
    input  logic              rx_valid,
    output logic [DATA_W-1:0] dout,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              rd_err
);

    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(MEM_DEPTH);
    localparam logic [ADDR_W:0] LAST_X  = (ADDR_W+1)'(MEM_DEPTH - 1);

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH_X);
    endfunction

    // Wraps at MEM_DEPTH-1; anything already out of range also lands on 0.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        if ({1'b0, a} >= LAST_X) return '0;
        return a + 1'b1;
    endfunction

    cmd_e              cmd;
    logic [DATA_W-1:0] payload;
    logic [ADDR_W-1:0] addr_pl;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              is_wr;
    logic              is_rd;
    logic              rd_accept;
    logic              rd_drop;
    logic              dout_zero;
    logic [DATA_W-1:0] mem_rdata;

    assign cmd       = cmd_e'(din[DATA_W+1:DATA_W]);
    assign payload   = din[DATA_W-1:0];
    assign addr_pl   = payload[ADDR_W-1:0];
    assign is_wr     = rx_valid && (cmd == CMD_WR_DATA);
    assign is_rd     = rx_valid && (cmd == CMD_RD_DATA);
    assign rd_accept = is_rd && (!tx_valid || tx_ready);
    assign rd_drop   = is_rd && tx_valid && !tx_ready;

    spi_ram_mem #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (is_wr && in_range(wr_addr)),
        .waddr (wr_addr),
        .wdata (payload),
        .re    (rd_accept && in_range(rd_addr)),
        .raddr (rd_addr),
        .rdata (mem_rdata)
    );

    // The memory read register only moves on accepted in-range reads, so it is the
    // tx holding register; dout_zero masks it after reset and for out-of-range reads.
    assign dout = dout_zero ? '0 : mem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr   <= '0;
            rd_addr   <= '0;
            tx_valid  <= 1'b0;
            rd_err    <= 1'b0;
            dout_zero <= 1'b1;
        end else begin
            rd_err <= rd_drop;

            if (rd_accept) begin
                tx_valid  <= 1'b1;
                dout_zero <= !in_range(rd_addr);
            end else if (tx_valid && tx_ready) begin
                tx_valid <= 1'b0;
            end

            if (rx_valid) begin
                case (cmd)
                    CMD_WR_ADDR: wr_addr <= addr_pl;
                    CMD_WR_DATA: if (AUTO_INC != 0) wr_addr <= next_addr(wr_addr);
                    CMD_RD_ADDR: rd_addr <= addr_pl;
                    CMD_RD_DATA: if (rd_accept && AUTO_INC != 0) rd_addr <= next_addr(rd_addr);
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_ram_burst.sv
// Directed bench: instance a (MEM_DEPTH=200, auto-increment) and instance b (fixed addresses).
module tb_spi_ram_burst;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] din_a = '0, din_b = '0;
    logic       rx_a = 1'b0, rx_b = 1'b0;
    logic       rdy_a = 1'b1, rdy_b = 1'b1;
    logic [7:0] dout_a, dout_b;
    logic       txv_a, txv_b, err_a, err_b;
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    spi_ram_burst #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(200), .AUTO_INC(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .din(din_a), .rx_valid(rx_a),
        .dout(dout_a), .tx_valid(txv_a), .tx_ready(rdy_a), .rd_err(err_a)
    );

    spi_ram_burst #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(256), .AUTO_INC(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .din(din_b), .rx_valid(rx_b),
        .dout(dout_b), .tx_valid(txv_b), .tx_ready(rdy_b), .rd_err(err_b)
    );

    // Drive one cycle of stimulus to instance a (sel=0) or b (sel=1); returns 1 time unit after the edge.
    task automatic tick(input bit sel, input logic [1:0] c, input logic [7:0] p, input bit v);
        din_a = {c, p};
        din_b = {c, p};
        rx_a  = v && !sel;
        rx_b  = v && sel;
        @(posedge clk);
        #1;
        rx_a = 1'b0;
        rx_b = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++; if (dout_a !== 8'h00) begin n_err++; $display("FAIL reset_dout: got %h want 00", dout_a); end
        n_cmp++; if (txv_a !== 1'b0)   begin n_err++; $display("FAIL reset_txv: got %b want 0", txv_a); end
        n_cmp++; if (err_a !== 1'b0)   begin n_err++; $display("FAIL reset_err: got %b want 0", err_a); end
        n_cmp++; if (txv_b !== 1'b0)   begin n_err++; $display("FAIL reset_txv_b: got %b want 0", txv_b); end
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_burst();
        logic [7:0] exp [3];
        exp[0] = 8'hA1; exp[1] = 8'hB2; exp[2] = 8'hC3;
        rdy_a = 1'b1;
        tick(0, 2'b00, 8'h10, 1);
        for (int i = 0; i < 3; i++) tick(0, 2'b01, exp[i], 1);
        tick(0, 2'b10, 8'h10, 1);
        for (int i = 0; i < 3; i++) begin
            tick(0, 2'b11, 8'h00, 1);
            n_cmp++; if (dout_a !== exp[i] || txv_a !== 1'b1 || err_a !== 1'b0) begin
                n_err++; $display("FAIL burst_rd%0d: got dout=%h txv=%b err=%b want %h 1 0", i, dout_a, txv_a, err_a, exp[i]);
            end
        end
        tick(0, 2'b11, 8'h00, 0);
        n_cmp++; if (txv_a !== 1'b0) begin n_err++; $display("FAIL burst_drain: got txv=%b want 0", txv_a); end
    endtask

    task automatic test_wrap();
        tick(0, 2'b00, 8'd199, 1);
        tick(0, 2'b01, 8'h11, 1);
        tick(0, 2'b01, 8'h22, 1);
        tick(0, 2'b10, 8'd199, 1);
        tick(0, 2'b11, 8'h00, 1);
        n_cmp++; if (dout_a !== 8'h11) begin n_err++; $display("FAIL wrap_rd199: got %h want 11", dout_a); end
        tick(0, 2'b11, 8'h00, 1);
        n_cmp++; if (dout_a !== 8'h22) begin n_err++; $display("FAIL wrap_rd0: got %h want 22", dout_a); end
        tick(0, 2'b10, 8'd0, 1);
        tick(0, 2'b11, 8'h00, 1);
        n_cmp++; if (dout_a !== 8'h22) begin n_err++; $display("FAIL wrap_mem0: got %h want 22", dout_a); end
        // Out-of-range read returns zero, then the pointer wraps to 0.
        tick(0, 2'b10, 8'd250, 1);
        tick(0, 2'b11, 8'h00, 1);
        n_cmp++; if (dout_a !== 8'h00 || txv_a !== 1'b1) begin
            n_err++; $display("FAIL oor_rd: got dout=%h txv=%b want 00 1", dout_a, txv_a);
        end
        tick(0, 2'b11, 8'h00, 1);
        n_cmp++; if (dout_a !== 8'h22) begin n_err++; $display("FAIL oor_wrap: got %h want 22", dout_a); end
        tick(0, 2'b00, 8'h00, 0);
    endtask

    task automatic test_backpressure();
        tick(0, 2'b10, 8'h10, 1);
        rdy_a = 1'b0;
        tick(0, 2'b11, 8'h00, 1);
        n_cmp++; if (dout_a !== 8'hA1 || txv_a !== 1'b1 || err_a !== 1'b0) begin
            n_err++; $display("FAIL bp_first: got dout=%h txv=%b err=%b want A1 1 0", dout_a, txv_a, err_a);
        end
        tick(0, 2'b11, 8'h00, 1);
        n_cmp++; if (dout_a !== 8'hA1 || txv_a !== 1'b1 || err_a !== 1'b1) begin
            n_err++; $display("FAIL bp_drop: got dout=%h txv=%b err=%b want A1 1 1", dout_a, txv_a, err_a);
        end
        tick(0, 2'b11, 8'h00, 0);
        n_cmp++; if (dout_a !== 8'hA1 || txv_a !== 1'b1 || err_a !== 1'b0) begin
            n_err++; $display("FAIL bp_hold: got dout=%h txv=%b err=%b want A1 1 0", dout_a, txv_a, err_a);
        end
        rdy_a = 1'b1;
        tick(0, 2'b00, 8'h00, 0);
        n_cmp++; if (txv_a !== 1'b0) begin n_err++; $display("FAIL bp_consume: got txv=%b want 0", txv_a); end
        tick(0, 2'b11, 8'h00, 1);
        n_cmp++; if (dout_a !== 8'hB2) begin n_err++; $display("FAIL bp_addr_once: got %h want B2", dout_a); end
        tick(0, 2'b00, 8'h00, 0);
    endtask

    task automatic test_back_to_back();
        rdy_a = 1'b1;
        tick(0, 2'b10, 8'h10, 1);
        tick(0, 2'b11, 8'h00, 1);
        tick(0, 2'b11, 8'h00, 1);
        n_cmp++; if (dout_a !== 8'hB2 || txv_a !== 1'b1 || err_a !== 1'b0) begin
            n_err++; $display("FAIL hs_read: got dout=%h txv=%b err=%b want B2 1 0", dout_a, txv_a, err_a);
        end
        tick(0, 2'b00, 8'h00, 0);
    endtask

    task automatic test_fixed_addr();
        tick(1, 2'b00, 8'd5, 1);
        tick(1, 2'b01, 8'h01, 1);
        tick(1, 2'b01, 8'h02, 1);
        tick(1, 2'b01, 8'h03, 1);
        tick(1, 2'b10, 8'd5, 1);
        for (int i = 0; i < 2; i++) begin
            tick(1, 2'b11, 8'h00, 1);
            n_cmp++; if (dout_b !== 8'h03 || txv_b !== 1'b1) begin
                n_err++; $display("FAIL fixed_rd%0d: got dout=%h txv=%b want 03 1", i, dout_b, txv_b);
            end
        end
        tick(1, 2'b00, 8'h00, 0);
    endtask

    task automatic test_async_reset();
        rdy_a = 1'b0;
        tick(0, 2'b10, 8'h10, 1);
        tick(0, 2'b11, 8'h00, 1);
        n_cmp++; if (txv_a !== 1'b1 || dout_a !== 8'hA1) begin
            n_err++; $display("FAIL ar_pre: got dout=%h txv=%b want A1 1", dout_a, txv_a);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (txv_a !== 1'b0 || dout_a !== 8'h00) begin
            n_err++; $display("FAIL ar_now: got dout=%h txv=%b want 00 0", dout_a, txv_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        rdy_a = 1'b1;
        tick(0, 2'b11, 8'h00, 1);
        n_cmp++; if (dout_a !== 8'h22 || txv_a !== 1'b1) begin
            n_err++; $display("FAIL ar_first: got dout=%h txv=%b want 22 1", dout_a, txv_a);
        end
        tick(0, 2'b10, 8'h11, 1);
        tick(0, 2'b11, 8'h00, 1);
        n_cmp++; if (dout_a !== 8'hB2) begin n_err++; $display("FAIL ar_kept: got %h want B2", dout_a); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_burst();
        test_wrap();
        test_backpressure();
        test_back_to_back();
        test_fixed_addr();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spi_ram_burst.md
SPI_RAM_BURST -- requirements
Module: spi_ram_burst

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8: word width.
REQ-002 The block SHALL have parameter ADDR_W, default 8: address width.
REQ-003 The block SHALL have parameter MEM_DEPTH, default 2**ADDR_W: number of words; legal range 2..2**ADDR_W.
REQ-004 The block SHALL have parameter AUTO_INC, default 1: 1 = post-increment addresses after each data access, 0 = fixed addresses.
REQ-005 Port clk, input, 1 bit: single clock, rising edge.
REQ-006 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 Port din, input, DATA_W+2 bits: bits [DATA_W+1:DATA_W] are the command, bits [DATA_W-1:0] are the payload.
REQ-008 Port rx_valid, input, 1 bit: din is valid this cycle.
REQ-009 Port dout, output, DATA_W bits: registered read data.
REQ-010 Port tx_valid, output, 1 bit: dout holds an unconsumed read word.
REQ-011 Port tx_ready, input, 1 bit: consumer accepts dout in a cycle where tx_valid=1.
REQ-012 Port rd_err, output, 1 bit: one-cycle pulse when a read command is dropped.

Function
REQ-013 Commands SHALL be decoded only when rx_valid=1; 00 = load wr_addr, 01 = write data, 10 = load rd_addr, 11 = read.
REQ-014 Address commands SHALL load payload[ADDR_W-1:0] into the address register; upper payload bits are ignored.
REQ-015 Write: mem[wr_addr] <= payload at the clock edge; if AUTO_INC=1, wr_addr advances by one in the same edge.
REQ-016 Read: dout <= mem[rd_addr] and tx_valid <= 1 at the edge after the command cycle (latency 1); if AUTO_INC=1, rd_addr advances by one.
REQ-017 Increments SHALL wrap from MEM_DEPTH-1 to 0, not from 2**ADDR_W-1.
REQ-018 Out-of-range address (>= MEM_DEPTH): writes are dropped, reads return all-zero with tx_valid=1; auto-increment of an out-of-range address wraps to 0.
REQ-019 tx_valid and dout SHALL hold stable until a cycle with tx_valid=1 and tx_ready=1, after which tx_valid clears unless a new read is accepted in that cycle.
REQ-020 A read while tx_valid=1 and tx_ready=0 SHALL be dropped: dout and rd_addr are unchanged and rd_err pulses for one cycle.
REQ-021 A read in the same cycle as a handshake (tx_valid=1, tx_ready=1) SHALL be accepted: dout is loaded with the new word and tx_valid stays 1.
REQ-022 A write to address A followed by a read of A in the next cycle SHALL return the new data; there is no bypass within a single cycle, since only one command arrives per cycle.
REQ-023 When rx_valid=0, no state other than the tx handshake SHALL change.

Reset
REQ-024 Asserting rst_n low SHALL immediately force dout=0, tx_valid=0, rd_err=0, wr_addr=0 and rd_addr=0, independent of clk.
REQ-025 Memory contents SHALL NOT be reset; a pending tx word is discarded on reset.
REQ-026 On the first edge after rst_n deasserts, commands SHALL be accepted normally.

Structure
REQ-027 The command codes CMD_WR_ADDR, CMD_WR_DATA, CMD_RD_ADDR and CMD_RD_DATA SHALL live in the shared package spi_ram_pkg.
REQ-028 Storage SHALL be one sub-module, spi_ram_mem (DATA_W x MEM_DEPTH, synchronous write, synchronous read, no reset); the address counters and the tx holding register stay in spi_ram_burst.

Verification
REQ-029 The bench SHALL cover burst write/read: 00/0x10, then 01/0xA1, 01/0xB2, 01/0xC3, then 10/0x10 and three 11 commands with tx_ready=1 -> dout 0xA1, 0xB2, 0xC3 on consecutive cycles, each 1 cycle after its command.
REQ-030 The bench SHALL cover wrap: MEM_DEPTH=200, write 0x11 at address 199 and then 0x22 -> 0x22 is stored at address 0; a read from 199 with two 11 commands -> 0x11, 0x22.
REQ-031 The bench SHALL cover back-pressure: tx_ready=0, two reads -> first word held with tx_valid=1, second dropped with rd_err=1 for 1 cycle and rd_addr advanced only once.
REQ-032 The bench SHALL cover simultaneous handshake and read: tx_valid=1, tx_ready=1 and an 11 command in the same cycle -> next dout is the new word, tx_valid stays 1, rd_err=0.
REQ-033 The bench SHALL cover AUTO_INC=0: three writes 0x01, 0x02, 0x03 to address 5 -> mem[5]=0x03; two reads -> 0x03 both times.
REQ-034 The bench SHALL cover asynchronous reset mid-burst: rst_n low between clock edges with tx_valid=1 -> tx_valid=0 and dout=0 immediately; data written before reset is still readable afterwards.
